// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan reader: active-low segment patterns
// ({a,b,c,d,e,f,g}, bit6 = a), special digit codes and the frame FSM states.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_ERR   = 4'hE;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_e;

endpackage

// File: rtl/seg7_pattern_to_code.sv
// Combinational inverse of a hex-to-7-segment decoder: active-low pattern to
// 4-bit code, with err_o flagging any pattern outside the known set.
module seg7_pattern_to_code
  import seg7_pkg::*;
(
  input  logic [6:0] seg_n_i,
  output logic [3:0] code_o,
  output logic       err_o
);

  always_comb begin
    code_o = CODE_ERR;
    err_o  = 1'b0;
    case (seg_n_i)
      SEG_0:     code_o = 4'h0;
      SEG_1:     code_o = 4'h1;
      SEG_2:     code_o = 4'h2;
      SEG_3:     code_o = 4'h3;
      SEG_4:     code_o = 4'h4;
      SEG_5:     code_o = 4'h5;
      SEG_6:     code_o = 4'h6;
      SEG_7:     code_o = 4'h7;
      SEG_8:     code_o = 4'h8;
      SEG_9:     code_o = 4'h9;
      SEG_DASH:  code_o = CODE_DASH;
      SEG_BLANK: code_o = CODE_BLANK;
      default:   err_o  = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_reader.sv
// Recovers hex frames from a multiplexed active-low 7-segment bus and offers
// them on valid/ready. Define SEG7_ERR_CNT_EN to add the err_count port.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned STABLE_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     an_n,
  input  logic [6:0]            seg_n,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic [4*DIGITS-1:0]   frame_data,
  output logic                  frame_err,
  output logic                  frame_ovr
`ifdef SEG7_ERR_CNT_EN
  ,
  output logic [15:0]           err_count
`endif
);

  localparam int unsigned    CW      = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYC);

  logic [DIGITS-1:0]   an_s1_q, an_s2_q, an_prev_q;
  logic [6:0]          seg_s1_q, seg_s2_q, seg_prev_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d, shadow_cap;
  logic [DIGITS-1:0]   mask_q, mask_d, mask_cap;
  logic [DIGITS-1:0]   err_q, err_d, err_cap;
  logic [4*DIGITS-1:0] frame_data_q, frame_data_d;
  logic                frame_err_q, frame_err_d;
  logic                ovr_q, ovr_d;
  state_e              state_q, state_d;

  logic [DIGITS-1:0]   sel;
  logic                one_hot, changed, cap, complete, load, drop;
  logic [3:0]          pat_code;
  logic                pat_err;

  seg7_pattern_to_code u_map (
    .seg_n_i (seg_s2_q),
    .code_o  (pat_code),
    .err_o   (pat_err)
  );

  assign sel     = ~an_s2_q;
  assign one_hot = $onehot(sel);
  assign changed = {an_s2_q, seg_s2_q} != {an_prev_q, seg_prev_q};

  // cnt counts cycles the current synced pair has been held, so a fresh pair
  // starts at 1 and capture lands 2+STABLE_CYC cycles after the pin change.
  always_comb begin
    cnt_d = cnt_q;
    if (!one_hot)              cnt_d = '0;
    else if (changed)          cnt_d = CW'(1);
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
    cap = one_hot && (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX);
  end

  always_comb begin
    shadow_cap = shadow_q;
    mask_cap   = mask_q;
    err_cap    = err_q;
    if (cap) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (sel[i]) begin
          shadow_cap[4*i +: 4] = pat_code;
          err_cap[i]           = pat_err;
          mask_cap[i]          = 1'b1;
        end
      end
    end
    complete = &mask_cap;
  end

  always_comb begin
    state_d      = state_q;
    frame_data_d = frame_data_q;
    frame_err_d  = frame_err_q;
    shadow_d     = shadow_cap;
    mask_d       = mask_cap;
    err_d        = err_cap;
    load         = 1'b0;
    drop         = 1'b0;
    case (state_q)
      COLLECT: begin
        if (complete) begin
          load    = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (frame_ready) begin
          if (complete) load    = 1'b1;
          else          state_d = COLLECT;
        end else if (complete) begin
          drop = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
    if (load) begin
      frame_data_d = shadow_cap;
      frame_err_d  = |err_cap;
    end
    if (load || drop) begin
      mask_d = '0;
      err_d  = '0;
    end
    ovr_d = drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1_q      <= '1;
      an_s2_q      <= '1;
      an_prev_q    <= '1;
      seg_s1_q     <= '1;
      seg_s2_q     <= '1;
      seg_prev_q   <= '1;
      cnt_q        <= '0;
      shadow_q     <= '1;
      mask_q       <= '0;
      err_q        <= '0;
      frame_data_q <= '0;
      frame_err_q  <= 1'b0;
      ovr_q        <= 1'b0;
      state_q      <= COLLECT;
    end else begin
      an_s1_q      <= an_n;
      an_s2_q      <= an_s1_q;
      an_prev_q    <= an_s2_q;
      seg_s1_q     <= seg_n;
      seg_s2_q     <= seg_s1_q;
      seg_prev_q   <= seg_s2_q;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      mask_q       <= mask_d;
      err_q        <= err_d;
      frame_data_q <= frame_data_d;
      frame_err_q  <= frame_err_d;
      ovr_q        <= ovr_d;
      state_q      <= state_d;
    end
  end

  assign frame_valid = (state_q == PRESENT);
  assign frame_data  = frame_data_q;
  assign frame_err   = frame_err_q;
  assign frame_ovr   = ovr_q;

`ifdef SEG7_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  err_cnt_q <= '0;
    else if (cap && pat_err && err_cnt_q != '1)  err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Self-checking bench for seg7_scan_reader (DIGITS=4, STABLE_CYC=16): directed
// frame table, multi-cycle corner sequences and randomized scans vs a model.
module tb_seg7_scan_reader;

  localparam int DIG = 4;
  localparam int STB = 16;

  localparam logic [6:0] PAT [12] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
    7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b1111110, 7'b1111111};
  localparam logic [3:0] PCODE [12] = '{
    4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hF};
  localparam logic [6:0] BAD = 7'b1010101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  an_n = '1;
  logic [6:0]  seg_n = '1;
  logic        frame_ready = 1'b0;
  logic        frame_valid, frame_err, frame_ovr;
  logic [15:0] frame_data;
`ifdef SEG7_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  int n_chk = 0;
  int n_fail = 0;

  seg7_scan_reader #(.DIGITS(DIG), .STABLE_CYC(STB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .frame_err   (frame_err),
    .frame_ovr   (frame_ovr)
`ifdef SEG7_ERR_CNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a digit is captured once its synced {an,seg} pair has
  // been seen for exactly STB consecutive edges (pins reach it 2 edges later).
  logic [10:0] p1, p2, p3, cur;
  int          run, mecnt;
  bit [3:0]    mmask, merr;
  logic [3:0]  mcode [4];
  bit          mpres, merrf, movr, oh, cap, e;
  logic [15:0] mdata;
  logic [3:0]  c;
  int          acc_cnt = 0;
  logic [15:0] acc_data = '0;
  logic        acc_err = 1'b0;
  int          ovr_cnt = 0;

  function automatic void decode(input logic [6:0] s, output logic [3:0] cd, output bit er);
    cd = 4'hE;
    er = 1'b1;
    for (int i = 0; i < 12; i++)
      if (PAT[i] == s) begin cd = PCODE[i]; er = 1'b0; end
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      p1 = '1; p2 = '1; p3 = '1; run = 0; mecnt = 0;
      mmask = '0; merr = '0; mpres = 0; merrf = 0; movr = 0; mdata = '0;
      for (int i = 0; i < 4; i++) mcode[i] = 4'hF;
    end else begin
      if (frame_valid && frame_ready) begin
        acc_cnt++;
        acc_data = frame_data;
        acc_err  = frame_err;
      end
      cur = p2;
      oh  = ($countones(~cur[10:7]) == 1);
      if (!oh)             run = 0;
      else if (cur != p3)  run = 1;
      else if (run < 1000) run++;
      cap = oh && (run == STB);
      if (cap) begin
        decode(cur[6:0], c, e);
        for (int i = 0; i < 4; i++)
          if (!cur[7+i]) begin mcode[i] = c; merr[i] = e; mmask[i] = 1'b1; end
        if (e && mecnt < 65535) mecnt++;
      end
      movr = 1'b0;
      if (mmask == 4'hF) begin
        if (!mpres || frame_ready) begin
          mdata = {mcode[3], mcode[2], mcode[1], mcode[0]};
          merrf = |merr;
          mpres = 1'b1;
        end else begin
          movr = 1'b1;
        end
        mmask = '0;
        merr  = '0;
      end else if (mpres && frame_ready) begin
        mpres = 1'b0;
      end
      p3 = p2; p2 = p1; p1 = {an_n, seg_n};
    end
  end

  initial forever begin
    @(negedge clk);
    if (frame_ovr) ovr_cnt++;
    chk("model_outputs", 32'({frame_valid, frame_err, frame_ovr, frame_data}),
        32'({mpres, merrf, movr, mdata}));
`ifdef SEG7_ERR_CNT_EN
    chk("model_err_count", 32'(err_count), 32'(mecnt));
`endif
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

  task automatic set(input logic [3:0] a, input logic [6:0] s, input int n);
    an_n  = a;
    seg_n = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic sd(input int d, input logic [6:0] s, input int n);
    set(~(4'b0001 << d), s, n);
  endtask

  typedef struct {
    logic [3:0][6:0] s;
    logic [15:0]     d;
    logic            e;
  } vec_t;

  vec_t tbl [4];
  int   c0, o0, idx;
  logic [3:0] ra;
  logic [6:0] rs;

  initial begin
    tbl[0] = '{s: {PAT[4], PAT[3], PAT[2], PAT[1]},   d: 16'h4321, e: 1'b0};
    tbl[1] = '{s: {PAT[4], PAT[3], BAD, PAT[1]},      d: 16'h43E1, e: 1'b1};
    tbl[2] = '{s: {PAT[7], PAT[6], PAT[5], PAT[0]},   d: 16'h7650, e: 1'b0};
    tbl[3] = '{s: {PAT[11], PAT[10], PAT[9], PAT[8]}, d: 16'hFA98, e: 1'b0};

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({frame_valid, frame_err, frame_ovr, frame_data}), 32'd0);
    rst_n = 1'b1;
    frame_ready = 1'b1;

    for (int t = 0; t < 4; t++) begin
      c0 = acc_cnt;
      for (int d = 0; d < 4; d++) sd(d, tbl[t].s[d], 40);
      set('1, '1, 10);
      chk("tbl_frames", 32'(acc_cnt), 32'(c0 + 1));
      chk("tbl_data", 32'(acc_data), 32'(tbl[t].d));
      chk("tbl_err", 32'(acc_err), 32'(tbl[t].e));
    end
`ifdef SEG7_ERR_CNT_EN
    chk("err_count_one", 32'(err_count), 32'd1);
`endif

    // Digit 2 too short to capture, then restored.
    c0 = acc_cnt;
    sd(0, PAT[1], 40); sd(1, PAT[2], 40); sd(2, PAT[3], 10); sd(3, PAT[4], 40);
    set('1, '1, 10);
    chk("short_no_frame", 32'(acc_cnt), 32'(c0));
    chk("short_no_valid", 32'(frame_valid), 32'd0);
    sd(2, PAT[3], 40);
    set('1, '1, 10);
    chk("short_frames", 32'(acc_cnt), 32'(c0 + 1));
    chk("short_data", 32'(acc_data), 32'h4321);

    // Dash/blank with all-anodes-low glitches held longer than STB.
    c0 = acc_cnt;
    sd(0, PAT[10], 40); set(4'b0000, PAT[10], 20);
    sd(1, PAT[11], 40); set(4'b0000, PAT[11], 20);
    sd(2, PAT[0], 40);  set(4'b0000, PAT[0], 20);
    sd(3, PAT[0], 40);
    set('1, '1, 10);
    chk("glitch_frames", 32'(acc_cnt), 32'(c0 + 1));
    chk("glitch_data", 32'(acc_data), 32'h00FA);

    // Consumer stalled across two complete scans.
    frame_ready = 1'b0;
    c0 = acc_cnt;
    o0 = ovr_cnt;
    for (int d = 0; d < 4; d++) sd(d, PAT[d+1], 40);
    for (int d = 0; d < 4; d++) sd(d, PAT[d+5], 40);
    set('1, '1, 10);
    chk("stall_ovr_pulses", 32'(ovr_cnt), 32'(o0 + 1));
    chk("stall_valid", 32'(frame_valid), 32'd1);
    chk("stall_data_held", 32'(frame_data), 32'h4321);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    chk("stall_handshake", 32'(acc_cnt), 32'(c0 + 1));
    chk("stall_valid_drop", 32'(frame_valid), 32'd0);

    // Asynchronous reset part-way through a scan.
    frame_ready = 1'b1;
    sd(0, PAT[9], 40); sd(1, PAT[8], 40); sd(2, PAT[3], 10);
    #1 rst_n = 1'b0;
    #1 chk("async_reset", 32'({frame_valid, frame_err, frame_ovr, frame_data}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    c0 = acc_cnt;
    sd(2, PAT[3], 40); sd(3, PAT[4], 40);
    set('1, '1, 10);
    chk("post_reset_partial", 32'(acc_cnt), 32'(c0));
    sd(0, PAT[1], 40); sd(1, PAT[2], 40);
    set('1, '1, 10);
    chk("post_reset_frames", 32'(acc_cnt), 32'(c0 + 1));
    chk("post_reset_data", 32'(acc_data), 32'h4321);

    // Randomized scanning against the model.
    repeat (250) begin
      if ($urandom_range(0, 9) == 0) ra = 4'($urandom);
      else                           ra = ~(4'b0001 << $urandom_range(0, 3));
      idx = int'($urandom_range(0, 11));
      if ($urandom_range(0, 4) == 0) rs = 7'($urandom);
      else                           rs = PAT[idx];
      frame_ready = 1'($urandom_range(0, 1));
      set(ra, rs, int'($urandom_range(1, 40)));
    end
    set('1, '1, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
